// File: rtl/iob_axi2mem_sub.sv
// iob_axi2mem_sub: AXI4 subordinate that replays AXI read/write bursts as single-word
// accesses on an Ibex-style memory port (req/gnt/rvalid). One memory access is in flight
// at a time and bursts are serialised beat by beat.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   aw*/w*/b*            AXI write address, write data and write response channels
//   ar*/r*               AXI read address and read data channels
//   mem_req_o/mem_gnt_i  memory request / grant handshake
//   mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o   memory request payload
//   mem_rvalid_i, mem_rdata_i, mem_err_i          memory response
//
// Optional feature: define IOB_AXI2MEM_WRAP_EN to accept WRAP bursts of 2/4/8/16 beats.
// Without it every WRAP burst is answered with SLVERR and never touches memory.

module iob_axi2mem_sub #(
   parameter int unsigned AXI_ID_W   = 1,
   parameter int unsigned AXI_ADDR_W = 32,
   parameter int unsigned AXI_DATA_W = 32,
   parameter int unsigned AXI_LEN_W  = 8,
   parameter int unsigned MEM_ADDR_W = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   // write address channel
   input  logic                    awvalid_i,
   output logic                    awready_o,
   input  logic [AXI_ADDR_W-1:0]   awaddr_i,
   input  logic [AXI_ID_W-1:0]     awid_i,
   input  logic [AXI_LEN_W-1:0]    awlen_i,
   input  logic [2:0]              awsize_i,
   input  logic [1:0]              awburst_i,
   // write data channel
   input  logic                    wvalid_i,
   output logic                    wready_o,
   input  logic [AXI_DATA_W-1:0]   wdata_i,
   input  logic [AXI_DATA_W/8-1:0] wstrb_i,
   input  logic                    wlast_i,
   // write response channel
   output logic                    bvalid_o,
   input  logic                    bready_i,
   output logic [1:0]              bresp_o,
   output logic [AXI_ID_W-1:0]     bid_o,
   // read address channel
   input  logic                    arvalid_i,
   output logic                    arready_o,
   input  logic [AXI_ADDR_W-1:0]   araddr_i,
   input  logic [AXI_ID_W-1:0]     arid_i,
   input  logic [AXI_LEN_W-1:0]    arlen_i,
   input  logic [2:0]              arsize_i,
   input  logic [1:0]              arburst_i,
   // read data channel
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [AXI_DATA_W-1:0]   rdata_o,
   output logic [1:0]              rresp_o,
   output logic [AXI_ID_W-1:0]     rid_o,
   output logic                    rlast_o,
   // memory port
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [AXI_DATA_W/8-1:0] mem_be_o,
   output logic [MEM_ADDR_W-1:0]   mem_addr_o,
   output logic [AXI_DATA_W-1:0]   mem_wdata_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   input  logic [AXI_DATA_W-1:0]   mem_rdata_i,
   input  logic                    mem_err_i
);

   localparam int unsigned StrbW = AXI_DATA_W / 8;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstWrap  = 2'b10;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StWrData,
      StWrMem,
      StWrWait,
      StWrResp,
      StRdMem,
      StRdWait,
      StRdResp
   } state_e;

   state_e                  r_state, w_state_nxt;
   logic [MEM_ADDR_W-1:0]   r_addr;
   logic [AXI_ID_W-1:0]     r_id;
   logic [AXI_LEN_W-1:0]    r_len;
   logic [AXI_LEN_W-1:0]    r_beat;
   logic [1:0]              r_burst;
   logic                    r_err;     // sticky write error
   logic                    r_bad;     // illegal command: no memory access for any beat
   logic [AXI_DATA_W-1:0]   r_wdata;
   logic [StrbW-1:0]        r_wstrb;
   logic [AXI_DATA_W-1:0]   r_rdata;
   logic [1:0]              r_rresp;
   logic                    r_rd_prio; // 1: read wins the next AW/AR contention

   logic                    w_sel_wr, w_sel_rd;
   logic                    w_last;
   logic                    w_wr_skip;
   logic                    w_aw_wrap_ok, w_ar_wrap_ok;
   logic                    w_aw_bad, w_ar_bad;
   logic [MEM_ADDR_W-1:0]   w_aw_addr, w_ar_addr;
   logic [MEM_ADDR_W-1:0]   w_addr_inc, w_addr_nxt;
   logic                    w_unused_addr;

   // Only the low MEM_ADDR_W bits reach memory; the byte offset is dropped.
   assign w_aw_addr     = {awaddr_i[MEM_ADDR_W-1:2], 2'b00};
   assign w_ar_addr     = {araddr_i[MEM_ADDR_W-1:2], 2'b00};
   assign w_unused_addr = ^{awaddr_i, araddr_i};

   // Single valid channel wins outright; on contention the channel not served last wins.
   assign w_sel_wr = awvalid_i & (~arvalid_i | ~r_rd_prio);
   assign w_sel_rd = arvalid_i & (~awvalid_i | r_rd_prio);

   assign w_last    = (r_beat == r_len);
   assign w_wr_skip = (wstrb_i == '0) | r_bad;

`ifdef IOB_AXI2MEM_WRAP_EN
   logic [MEM_ADDR_W-1:0] w_wrap_mask;

   assign w_aw_wrap_ok = (awlen_i == AXI_LEN_W'(1)) | (awlen_i == AXI_LEN_W'(3)) |
                         (awlen_i == AXI_LEN_W'(7)) | (awlen_i == AXI_LEN_W'(15));
   assign w_ar_wrap_ok = (arlen_i == AXI_LEN_W'(1)) | (arlen_i == AXI_LEN_W'(3)) |
                         (arlen_i == AXI_LEN_W'(7)) | (arlen_i == AXI_LEN_W'(15));
   // len+1 is a power of two here, so (len+1)*4-1 == (len<<2)|3.
   assign w_wrap_mask  = (MEM_ADDR_W'(r_len) << 2) | MEM_ADDR_W'(3);
`else
   assign w_aw_wrap_ok = 1'b0;
   assign w_ar_wrap_ok = 1'b0;
`endif

   assign w_aw_bad = (awsize_i != 3'd2) | ((awburst_i == BurstWrap) & ~w_aw_wrap_ok);
   assign w_ar_bad = (arsize_i != 3'd2) | ((arburst_i == BurstWrap) & ~w_ar_wrap_ok);

   // Per-beat address step; reserved burst encoding steps like INCR.
   always_comb begin
      w_addr_inc = r_addr + MEM_ADDR_W'(4);
      w_addr_nxt = w_addr_inc;
      if (r_burst == BurstFixed) begin
         w_addr_nxt = r_addr;
      end
`ifdef IOB_AXI2MEM_WRAP_EN
      else if (r_burst == BurstWrap) begin
         w_addr_nxt = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      end
`endif
   end

   // Next state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      awready_o   = 1'b0;
      arready_o   = 1'b0;
      wready_o    = 1'b0;
      bvalid_o    = 1'b0;
      rvalid_o    = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      case (r_state)
         StIdle: begin
            awready_o = w_sel_wr;
            arready_o = w_sel_rd;
            if (w_sel_wr) begin
               w_state_nxt = StWrData;
            end else if (w_sel_rd) begin
               w_state_nxt = w_ar_bad ? StRdResp : StRdMem;
            end
         end
         StWrData: begin
            wready_o = 1'b1;
            if (wvalid_i) begin
               if (!w_wr_skip)  w_state_nxt = StWrMem;
               else if (w_last) w_state_nxt = StWrResp;
            end
         end
         StWrMem: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            mem_be_o  = r_wstrb;
            if (mem_gnt_i) w_state_nxt = StWrWait;
         end
         StWrWait: begin
            if (mem_rvalid_i) w_state_nxt = w_last ? StWrResp : StWrData;
         end
         StWrResp: begin
            bvalid_o = 1'b1;
            if (bready_i) w_state_nxt = StIdle;
         end
         StRdMem: begin
            mem_req_o = 1'b1;
            mem_be_o  = '1;
            if (mem_gnt_i) w_state_nxt = StRdWait;
         end
         StRdWait: begin
            if (mem_rvalid_i) w_state_nxt = StRdResp;
         end
         StRdResp: begin
            rvalid_o = 1'b1;
            if (rready_i) begin
               if (w_last)     w_state_nxt = StIdle;
               else if (r_bad) w_state_nxt = StRdResp;
               else            w_state_nxt = StRdMem;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign bresp_o     = ((r_state == StWrResp) && (r_err || r_bad)) ? RespSlvErr : RespOkay;
   assign bid_o       = r_id;
   assign rdata_o     = r_rdata;
   assign rresp_o     = r_rresp;
   assign rid_o       = r_id;
   assign rlast_o     = (r_state == StRdResp) & w_last;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_addr    <= '0;
         r_id      <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_burst   <= '0;
         r_err     <= 1'b0;
         r_bad     <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
         r_rresp   <= RespOkay;
         r_rd_prio <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_sel_wr) begin
                  r_rd_prio <= 1'b1;
                  r_addr    <= w_aw_addr;
                  r_id      <= awid_i;
                  r_len     <= awlen_i;
                  r_burst   <= awburst_i;
                  r_bad     <= w_aw_bad;
                  r_beat    <= '0;
                  r_err     <= 1'b0;
               end else if (w_sel_rd) begin
                  r_rd_prio <= 1'b0;
                  r_addr    <= w_ar_addr;
                  r_id      <= arid_i;
                  r_len     <= arlen_i;
                  r_burst   <= arburst_i;
                  r_bad     <= w_ar_bad;
                  r_beat    <= '0;
                  r_err     <= 1'b0;
                  // A bad burst answers every beat from these values.
                  r_rdata   <= '0;
                  r_rresp   <= w_ar_bad ? RespSlvErr : RespOkay;
               end
            end
            StWrData: begin
               if (wvalid_i) begin
                  r_wdata <= wdata_i;
                  r_wstrb <= wstrb_i;
                  // Flag a misplaced wlast but let the beat count end the burst.
                  if (wlast_i != w_last) r_err <= 1'b1;
                  if (w_wr_skip && !w_last) begin
                     r_beat <= r_beat + AXI_LEN_W'(1);
                     r_addr <= w_addr_nxt;
                  end
               end
            end
            StWrWait: begin
               if (mem_rvalid_i) begin
                  if (mem_err_i) r_err <= 1'b1;
                  if (!w_last) begin
                     r_beat <= r_beat + AXI_LEN_W'(1);
                     r_addr <= w_addr_nxt;
                  end
               end
            end
            StRdWait: begin
               if (mem_rvalid_i) begin
                  r_rdata <= mem_rdata_i;
                  r_rresp <= mem_err_i ? RespSlvErr : RespOkay;
               end
            end
            StRdResp: begin
               if (rready_i && !w_last) begin
                  r_beat <= r_beat + AXI_LEN_W'(1);
                  r_addr <= w_addr_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_axi2mem_sub.sv
// Directed self-checking bench for iob_axi2mem_sub. A small memory responder grants
// requests after a programmable delay, logs each request and returns queued data/errors.

module tb_iob_axi2mem_sub;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        awvalid_i = 1'b0, awready_o;
   logic [31:0] awaddr_i = '0;
   logic [0:0]  awid_i = '0;
   logic [7:0]  awlen_i = '0;
   logic [2:0]  awsize_i = '0;
   logic [1:0]  awburst_i = '0;
   logic        wvalid_i = 1'b0, wready_o;
   logic [31:0] wdata_i = '0;
   logic [3:0]  wstrb_i = '0;
   logic        wlast_i = 1'b0;
   logic        bvalid_o, bready_i = 1'b0;
   logic [1:0]  bresp_o;
   logic [0:0]  bid_o;
   logic        arvalid_i = 1'b0, arready_o;
   logic [31:0] araddr_i = '0;
   logic [0:0]  arid_i = '0;
   logic [7:0]  arlen_i = '0;
   logic [2:0]  arsize_i = '0;
   logic [1:0]  arburst_i = '0;
   logic        rvalid_o, rready_i = 1'b0;
   logic [31:0] rdata_o;
   logic [1:0]  rresp_o;
   logic [0:0]  rid_o;
   logic        rlast_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_rdata_i;

   always #5 clk_i = ~clk_i;

   iob_axi2mem_sub dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .awvalid_i   (awvalid_i),
      .awready_o   (awready_o),
      .awaddr_i    (awaddr_i),
      .awid_i      (awid_i),
      .awlen_i     (awlen_i),
      .awsize_i    (awsize_i),
      .awburst_i   (awburst_i),
      .wvalid_i    (wvalid_i),
      .wready_o    (wready_o),
      .wdata_i     (wdata_i),
      .wstrb_i     (wstrb_i),
      .wlast_i     (wlast_i),
      .bvalid_o    (bvalid_o),
      .bready_i    (bready_i),
      .bresp_o     (bresp_o),
      .bid_o       (bid_o),
      .arvalid_i   (arvalid_i),
      .arready_o   (arready_o),
      .araddr_i    (araddr_i),
      .arid_i      (arid_i),
      .arlen_i     (arlen_i),
      .arsize_i    (arsize_i),
      .arburst_i   (arburst_i),
      .rvalid_o    (rvalid_o),
      .rready_i    (rready_i),
      .rdata_o     (rdata_o),
      .rresp_o     (rresp_o),
      .rid_o       (rid_o),
      .rlast_o     (rlast_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_be_o    (mem_be_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i),
      .mem_err_i   (mem_err_i)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] rsp_data[$];
   logic        rsp_err[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_wd[$];
   logic [3:0]  log_be[$];
   logic        log_we[$];
   int          gnt_delay = 0;
   int          gnt_wait = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory responder: grant after gnt_delay cycles, respond the cycle after the grant.
   initial begin
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
      mem_err_i = 1'b0;
      forever begin
         @(negedge clk_i);
         mem_rvalid_i = 1'b0;
         mem_err_i = 1'b0;
         mem_rdata_i = '0;
         if (!rst_ni) begin
            mem_gnt_i = 1'b0;
            gnt_wait = gnt_delay;
         end else if (mem_gnt_i) begin
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b1;
            if (rsp_data.size() > 0) mem_rdata_i = rsp_data.pop_front();
            if (rsp_err.size() > 0) mem_err_i = rsp_err.pop_front();
         end else if (mem_req_o) begin
            if (gnt_wait == 0) begin
               mem_gnt_i = 1'b1;
               log_addr.push_back(mem_addr_o);
               log_wd.push_back(mem_wdata_o);
               log_be.push_back(mem_be_o);
               log_we.push_back(mem_we_o);
               gnt_wait = gnt_delay;
            end else begin
               gnt_wait--;
            end
         end
      end
   end

   task automatic push_rsp(input logic [31:0] d, input logic e);
      rsp_data.push_back(d);
      rsp_err.push_back(e);
   endtask

   task automatic aw_send(input logic [31:0] addr, input logic [0:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int t = 0;
      awvalid_i = 1'b1; awaddr_i = addr; awid_i = id; awlen_i = len;
      awsize_i = size; awburst_i = burst;
      #1;
      while (!awready_o && t < 50) begin @(negedge clk_i); #1; t++; end
      chk("aw_accept", awready_o, 1);
      @(negedge clk_i);
      awvalid_i = 1'b0;
   endtask

   task automatic ar_send(input logic [31:0] addr, input logic [0:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int t = 0;
      arvalid_i = 1'b1; araddr_i = addr; arid_i = id; arlen_i = len;
      arsize_i = size; arburst_i = burst;
      #1;
      while (!arready_o && t < 50) begin @(negedge clk_i); #1; t++; end
      chk("ar_accept", arready_o, 1);
      @(negedge clk_i);
      arvalid_i = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int t = 0;
      wvalid_i = 1'b1; wdata_i = data; wstrb_i = strb; wlast_i = last;
      #1;
      while (!wready_o && t < 50) begin @(negedge clk_i); #1; t++; end
      chk("w_accept", wready_o, 1);
      @(negedge clk_i);
      wvalid_i = 1'b0;
   endtask

   task automatic b_recv(input string tag, input logic [1:0] resp, input logic [0:0] id);
      int t = 0;
      bready_i = 1'b1;
      #1;
      while (!bvalid_o && t < 50) begin @(negedge clk_i); #1; t++; end
      chk($sformatf("%s_bvalid", tag), bvalid_o, 1);
      chk($sformatf("%s_bresp", tag), bresp_o, resp);
      chk($sformatf("%s_bid", tag), bid_o, id);
      @(negedge clk_i);
      bready_i = 1'b0;
   endtask

   // Waits for an R beat with rready low, holds it for 'hold' cycles, then accepts it.
   task automatic r_recv(input string tag, input logic [31:0] data, input logic [1:0] resp,
                         input logic last, input logic [0:0] id, input int hold);
      int t = 0;
      rready_i = 1'b0;
      #1;
      while (!rvalid_o && t < 50) begin @(negedge clk_i); #1; t++; end
      chk($sformatf("%s_rvalid", tag), rvalid_o, 1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk_i); #1;
         chk($sformatf("%s_hold%0d", tag, h), {rvalid_o, rdata_o}, {1'b1, data});
      end
      chk($sformatf("%s_rdata", tag), rdata_o, data);
      chk($sformatf("%s_rresp", tag), rresp_o, resp);
      chk($sformatf("%s_rlast", tag), rlast_o, last);
      chk($sformatf("%s_rid", tag), rid_o, id);
      rready_i = 1'b1;
      @(negedge clk_i);
      rready_i = 1'b0;
   endtask

   task automatic chk_log(input string tag, input int idx, input logic [31:0] addr,
                          input logic we, input logic [3:0] be, input logic [31:0] wd);
      if (idx >= log_addr.size()) begin
         chk($sformatf("%s_present", tag), 0, 1);
      end else begin
         chk($sformatf("%s_addr", tag), log_addr[idx], addr);
         chk($sformatf("%s_we", tag), log_we[idx], we);
         chk($sformatf("%s_be", tag), log_be[idx], be);
         if (we) chk($sformatf("%s_wdata", tag), log_wd[idx], wd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      logic [31:0] wrap_addr [4];
      wrap_addr[0] = 32'h1C; wrap_addr[1] = 32'h10; wrap_addr[2] = 32'h14; wrap_addr[3] = 32'h18;

      // Reset state
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_ctrl", {awready_o, arready_o, wready_o, bvalid_o, rvalid_o, mem_req_o,
                       mem_we_o, rlast_o}, 0);
      chk("rst_resp", {bresp_o, rresp_o, mem_be_o}, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_maddr", mem_addr_o, 0);
      chk("rst_mwdata", mem_wdata_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Contention twice after reset: write first, then read
      push_rsp(32'h0, 1'b0);
      awvalid_i = 1'b1; awaddr_i = 32'h40; awid_i = 1'b1; awlen_i = 8'd0;
      awsize_i = 3'd2; awburst_i = 2'b01;
      arvalid_i = 1'b1; araddr_i = 32'h80; arid_i = 1'b0; arlen_i = 8'd0;
      arsize_i = 3'd2; arburst_i = 2'b01;
      #1;
      chk("rr1_ready", {awready_o, arready_o}, 2'b10);
      @(negedge clk_i);
      awvalid_i = 1'b0;
      w_send(32'hA5A5_A5A5, 4'hF, 1'b1);
      b_recv("rr1", 2'b00, 1'b1);
      awvalid_i = 1'b1; awaddr_i = 32'h44;
      #1;
      chk("rr2_ready", {awready_o, arready_o}, 2'b01);
      @(negedge clk_i);
      awvalid_i = 1'b0; arvalid_i = 1'b0;
      push_rsp(32'h1234_5678, 1'b0);
      r_recv("rr2", 32'h1234_5678, 2'b00, 1'b1, 1'b0, 0);
      chk_log("rr_mem0", 0, 32'h40, 1'b1, 4'hF, 32'hA5A5_A5A5);
      chk_log("rr_mem1", 1, 32'h80, 1'b0, 4'hF, 32'h0);

      // Single write with grant after 2 cycles
      base = log_addr.size();
      gnt_delay = 2; gnt_wait = 2;
      push_rsp(32'h0, 1'b0);
      aw_send(32'h100, 1'b1, 8'd0, 3'd2, 2'b01);
      w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
      b_recv("wr1", 2'b00, 1'b1);
      chk("wr1_nreq", log_addr.size() - base, 1);
      chk_log("wr1_mem", base, 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
      gnt_delay = 0; gnt_wait = 0;

      // INCR read of 4 beats, first beat held 3 cycles; mem_req one cycle after AR
      base = log_addr.size();
      push_rsp(32'h11, 1'b0); push_rsp(32'h22, 1'b0);
      push_rsp(32'h33, 1'b0); push_rsp(32'h44, 1'b0);
      ar_send(32'h200, 1'b0, 8'd3, 3'd2, 2'b01);
      chk("rd_req_lat", mem_req_o, 1);
      r_recv("rd0", 32'h11, 2'b00, 1'b0, 1'b0, 3);
      r_recv("rd1", 32'h22, 2'b00, 1'b0, 1'b0, 0);
      r_recv("rd2", 32'h33, 2'b00, 1'b0, 1'b0, 0);
      r_recv("rd3", 32'h44, 2'b00, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         chk_log($sformatf("rd_mem%0d", i), base + i, 32'h200 + 32'(4 * i), 1'b0, 4'hF, 0);
      end

      // Write error on beat 0: both writes still issued, SLVERR
      base = log_addr.size();
      push_rsp(32'h0, 1'b1); push_rsp(32'h0, 1'b0);
      aw_send(32'h300, 1'b0, 8'd1, 3'd2, 2'b01);
      w_send(32'h0000_0001, 4'hF, 1'b0);
      w_send(32'h0000_0002, 4'h3, 1'b1);
      b_recv("wrerr", 2'b10, 1'b0);
      chk("wrerr_nreq", log_addr.size() - base, 2);
      chk_log("wrerr_mem1", base + 1, 32'h304, 1'b1, 4'h3, 32'h2);

      // Read error on beat 1 of 2
      push_rsp(32'hAA, 1'b0); push_rsp(32'hBB, 1'b1);
      ar_send(32'h400, 1'b1, 8'd1, 3'd2, 2'b01);
      r_recv("rderr0", 32'hAA, 2'b00, 1'b0, 1'b1, 0);
      r_recv("rderr1", 32'hBB, 2'b10, 1'b1, 1'b1, 0);

      // Illegal read size: no memory access, SLVERR beats with zero data
      base = log_addr.size();
      ar_send(32'h500, 1'b0, 8'd1, 3'd1, 2'b01);
      r_recv("ill0", 32'h0, 2'b10, 1'b0, 1'b0, 0);
      r_recv("ill1", 32'h0, 2'b10, 1'b1, 1'b0, 0);
      chk("ill_nreq", log_addr.size() - base, 0);

      // Write with zero strobe: no memory access, OKAY
      aw_send(32'h600, 1'b1, 8'd0, 3'd2, 2'b01);
      w_send(32'h99, 4'h0, 1'b1);
      b_recv("nostrb", 2'b00, 1'b1);
      chk("nostrb_nreq", log_addr.size() - base, 0);

      // WRAP burst
      base = log_addr.size();
`ifdef IOB_AXI2MEM_WRAP_EN
      push_rsp(32'hA0, 1'b0); push_rsp(32'hA1, 1'b0);
      push_rsp(32'hA2, 1'b0); push_rsp(32'hA3, 1'b0);
      ar_send(32'h1C, 1'b0, 8'd3, 3'd2, 2'b10);
      for (int i = 0; i < 4; i++) begin
         r_recv($sformatf("wrap%0d", i), 32'hA0 + 32'(i), 2'b00, i == 3, 1'b0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         chk_log($sformatf("wrap_mem%0d", i), base + i, wrap_addr[i], 1'b0, 4'hF, 0);
      end
`else
      ar_send(32'h1C, 1'b0, 8'd3, 3'd2, 2'b10);
      for (int i = 0; i < 4; i++) begin
         r_recv($sformatf("wrap%0d", i), 32'h0, 2'b10, i == 3, 1'b0, 0);
      end
      chk("wrap_nreq", log_addr.size() - base, 0);
`endif

      // Reset in the middle of a read burst
      rsp_data.delete(); rsp_err.delete();
      push_rsp(32'h55, 1'b0); push_rsp(32'h66, 1'b0);
      ar_send(32'h700, 1'b1, 8'd3, 3'd2, 2'b01);
      begin
         int t = 0;
         #1;
         while (!rvalid_o && t < 50) begin @(negedge clk_i); #1; t++; end
      end
      chk("mid_rdata", {rvalid_o, rdata_o}, {1'b1, 32'h55});
      rst_ni = 1'b0;
      @(negedge clk_i);
      #1;
      chk("mid_rst_ctrl", {rvalid_o, rlast_o, mem_req_o, mem_we_o, bvalid_o, wready_o}, 0);
      chk("mid_rst_rdata", rdata_o, 0);
      chk("mid_rst_resp", {rresp_o, bresp_o, rid_o, bid_o, mem_be_o}, 0);
      chk("mid_rst_maddr", mem_addr_o, 0);
      chk("mid_rst_mwdata", mem_wdata_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      rsp_data.delete(); rsp_err.delete();
      @(negedge clk_i);

      // Normal operation after the abandoned burst
      base = log_addr.size();
      push_rsp(32'h77, 1'b0);
      ar_send(32'h10, 1'b0, 8'd0, 3'd2, 2'b00);
      r_recv("post", 32'h77, 2'b00, 1'b1, 1'b0, 0);
      chk_log("post_mem", base, 32'h10, 1'b0, 4'hF, 0);

      repeat (2) @(negedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iob_axi2mem_sub.md
Name: iob_axi2mem_sub

Overview:
- AXI4 subordinate that accepts AXI read and write bursts and replays them as single-word accesses on an Ibex-style memory port (req/gnt/rvalid).
- It is the responder counterpart of the Ibex-LSU-to-AXI bridge. It lets AXI managers (DMA, debug, second core) reach Ibex-side RAM or peripherals.
- One memory transaction is outstanding at a time. AXI bursts are serialised beat by beat.

Parameters:
- AXI_ID_W, 1, width of ID fields (echoed unchanged)
- AXI_ADDR_W, 32, AXI address width
- AXI_DATA_W, 32, data width; only 32 is supported, so strobe is 4 bits
- AXI_LEN_W, 8, burst length field width
- MEM_ADDR_W, 32, memory port address width; low MEM_ADDR_W bits of AXI address, with [1:0] forced to 0

Ports:
- clk_i in 1 clock
- rst_ni in 1 synchronous active-low reset
- awvalid_i/awready_o in/out 1; awaddr_i in AXI_ADDR_W; awid_i in AXI_ID_W; awlen_i in AXI_LEN_W; awsize_i in 3; awburst_i in 2
- wvalid_i/wready_o in/out 1; wdata_i in 32; wstrb_i in 4; wlast_i in 1
- bvalid_o/bready_i out/in 1; bresp_o out 2; bid_o out AXI_ID_W
- arvalid_i/arready_o in/out 1; araddr_i in AXI_ADDR_W; arid_i in AXI_ID_W; arlen_i in AXI_LEN_W; arsize_i in 3; arburst_i in 2
- rvalid_o/rready_i out/in 1; rdata_o out 32; rresp_o out 2; rid_o out AXI_ID_W; rlast_o out 1
- mem_req_o out 1 request; mem_we_o out 1 write enable; mem_be_o out 4 byte enables; mem_addr_o out MEM_ADDR_W; mem_wdata_o out 32
- mem_gnt_i in 1 grant; mem_rvalid_i in 1 response valid; mem_rdata_i in 32; mem_err_i in 1 error, valid with mem_rvalid_i

Behaviour:
- Reset (rst_ni low at a clk_i edge): state IDLE; all valid/ready/req outputs 0; bresp_o/rresp_o 0; rdata_o 0; rlast_o 0; mem_* 0; round-robin pointer selects write first. A reset mid-burst abandons it silently, including any pending memory response.
- FSM states: IDLE, WR_DATA, WR_MEM, WR_WAIT, WR_RESP, RD_MEM, RD_WAIT, RD_RESP.
- IDLE: awready_o/arready_o are combinational, high only for the selected channel.
  - If only one channel is valid, that channel is selected.
  - If both are valid, the channel not served last is selected; the pointer updates on each accepted address.
  - On accept, register addr (word aligned), id, len, burst, beat counter = 0, sticky error = 0.
  - Illegal command: size != 3'd2 or burst == WRAP. The whole burst is flagged bad; no memory access is made for any beat.
- Write path:
  - WR_DATA: wready_o = 1. On handshake, capture wdata/wstrb.
  - If wstrb == 0 or the burst is bad, skip memory and advance the beat; otherwise go to WR_MEM.
  - WR_MEM: mem_req_o = 1, mem_we_o = 1, mem_be_o = wstrb; hold all mem_* stable until mem_gnt_i, then go to WR_WAIT.
  - WR_WAIT: on mem_rvalid_i, set sticky error |= mem_err_i and advance the beat.
  - wlast_i mismatch (high before the final beat, or low on the final beat) sets sticky error. The beat count alone decides burst end.
  - After beat len, go to WR_RESP: bvalid_o = 1, bid_o = id, bresp_o = sticky error ? 2'b10 : 2'b00. Hold until bready_i, then IDLE.
- Read path:
  - RD_MEM: mem_req_o = 1, mem_we_o = 0, mem_be_o = 4'hF; hold until mem_gnt_i, then go to RD_WAIT.
  - RD_WAIT: on mem_rvalid_i, register rdata_o = mem_rdata_i and rresp_o = mem_err_i ? 2'b10 : 2'b00, then go to RD_RESP.
  - Bad burst: skip RD_MEM/RD_WAIT; rdata_o = 0, rresp_o = 2'b10.
  - RD_RESP: rvalid_o = 1, rid_o = id, rlast_o = (beat == len). rdata/rresp/rlast stay stable until rready_i.
  - On handshake: return to IDLE if last, otherwise go to RD_MEM (or straight to RD_RESP for a bad burst).
- Address update per beat: INCR adds 4 (wraps modulo 2^MEM_ADDR_W); FIXED holds the address.
- Latency: AR handshake at cycle N gives mem_req_o at N+1; mem_rvalid_i at cycle M gives rvalid_o at M+1.
- Per-beat error on reads does not abort the burst; all len+1 beats are always returned.
- mem_rvalid_i outside WR_WAIT/RD_WAIT is ignored.

Optional Feature:
- Macro: IOB_AXI2MEM_WRAP_EN.
- Defined: WRAP bursts are legal when len is in {1, 3, 7, 15}. Address wraps within an aligned (len+1)*4-byte window: addr = (addr & ~mask) | ((addr + 4) & mask), with mask = (len+1)*4 - 1. WRAP with any other len is bad.
- Not defined: every WRAP burst is bad (SLVERR, no memory access).

Test Plan:
- Single write: awaddr=0x100, len=0, wdata=0xDEADBEEF, wstrb=0xF; gnt after 2 cycles → one mem_req with addr 0x100, be F, data DEADBEEF; bresp=00, bid echoes awid.
- INCR read: araddr=0x200, len=3; memory returns 0x11, 0x22, 0x33, 0x44 → mem addrs 0x200/204/208/20C; 4 R beats in order, rlast only on the 4th. With rready held low 3 cycles, data stays stable.
- Error: 2-beat write, mem_err_i on beat 0 → both memory writes still issued; bresp=10. Read with mem_err_i on beat 1 of 2 → rresp = 00 then 10.
- Simultaneous AW and AR valid in IDLE twice in a row after reset → write served first, then read (round-robin).
- Illegal command: arsize=1, len=1 → no mem_req; 2 beats with rresp=10, rdata=0. Write with wstrb=0 → no mem_req, bresp=00.
- WRAP burst: araddr=0x1C, len=3 → with IOB_AXI2MEM_WRAP_EN: addrs 0x1C, 0x10, 0x14, 0x18. Without it: 4 beats of SLVERR and no memory access. Then assert reset mid-burst → all outputs return to 0 next cycle.
